// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider for DIV: {remainder, quotient} from Y / bus, one quotient bit per clock.
// Define SEQ_DIV_UNSIGNED_EN to add the div_unsigned_i port for unsigned division.
module seq_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic               div_unsigned_i,
`endif
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
  logic                 qneg_q, rneg_q, dbz_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 uns, a_neg, b_neg, last, accept;
  logic [WIDTH-1:0]     a_mag, b_mag, rem_nx, quo_nx, quo_fin, rem_fin;
  logic [WIDTH:0]       rem_sh, trial;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign uns = div_unsigned_i;
`else
  assign uns = 1'b0;
`endif

  // Most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign a_neg  = dividend_i[WIDTH-1] & ~uns;
  assign b_neg  = divisor_i[WIDTH-1] & ~uns;
  assign a_mag  = a_neg ? -dividend_i : dividend_i;
  assign b_mag  = b_neg ? -divisor_i  : divisor_i;
  assign accept = (state_q == IDLE) && start_i;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_fin = qneg_q ? -quo_nx : quo_nx;
  assign rem_fin = rneg_q ? -rem_nx : rem_nx;
  assign last    = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (divisor_i == '0) ? DONE : RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= a_mag;
      dvs_q  <= b_mag;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dbz_q  <= (divisor_i == '0);
      if (divisor_i == '0) result_q <= {dividend_i, {WIDTH{1'b1}}};
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (last) result_q <= {rem_fin, quo_fin};
    end
  end

  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit: signed cases, divide-by-zero, overflow, ignored start, mid-run reset.
module tb_seq_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, dbz;
  logic [63:0] result;
  logic        dun;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  seq_div_unit dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
`ifdef SEQ_DIV_UNSIGNED_EN
    .div_unsigned_i(dun),
`endif
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result),
    .div_by_zero_o (dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;  // operands must have been captured at the accepting edge
    divisor  = 32'h0000_0001;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp_res, input logic exp_dbz,
                           input int exp_lat);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
    chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
    tick();
    chk({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input logic exp_dbz);
    launch(a, b);
    wait_done(tag, exp_res, exp_dbz, exp_dbz ? 0 : 32);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; dun = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_dbz", {63'd0, dbz}, 64'd0);

    run_div("p100_p7", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    tick(); tick();
    chk("result_hold", result, 64'h00000002_0000000E);
    run_div("m100_p7", 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
    run_div("p100_m7", 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0);
    run_div("m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0);
    run_div("div0", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
    tick();
    chk("div0_hold_dbz", {63'd0, dbz}, 64'd1);
    run_div("p9_p3", 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);
    run_div("ovf", 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_div("zero_m5", 32'd0, 32'hFFFFFFFB, 64'd0, 1'b0);

    // start during RUN is ignored
    launch(32'd100, 32'd7);
    repeat (5) tick();
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_start", 64'h00000002_0000000E, 1'b0, 26);

    // start held high: next division begins on the first IDLE edge after done
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    dividend = 32'd20; divisor = 32'd6;
    tick();  // DONE -> IDLE
    tick();  // IDLE accepts held start
    start = 1'b0;
    chk("held_start_busy", {63'd0, busy}, 64'd1);
    wait_done("held_start", 64'h00000002_00000003, 1'b0, 32);

    // reset in the middle of a run aborts without a done pulse
    launch(32'd100, 32'd7);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n++;
    end
    chk("abort_no_done", 64'(n), 64'd0);

`ifdef SEQ_DIV_UNSIGNED_EN
    dun = 1'b1;
    run_div("uns_ffff_2", 32'hFFFFFFFF, 32'd2, 64'h00000001_7FFFFFFF, 1'b0);
    dun = 1'b0;
    run_div("sgn_ffff_2", 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_00000000, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multi-cycle signed integer divider for the DIV instruction.
- Sits directly downstream of the datapath's Y register and bus. Dividend comes from Y, divisor from bus.
- Its 64-bit result feeds the Z register input, alongside the single-cycle ALU result: remainder in the upper half (Zhigh → HI), quotient in the lower half (Zlow → LO).
- Uses restoring division on magnitudes, one quotient bit per clock, with a start/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  dividend, two's complement (from Y).
- divisor  input  WIDTH  divisor, two's complement (from bus).
- busy  output  1  high from the edge that accepts start until done.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  2*WIDTH  {remainder, quotient}.
- div_by_zero  output  1  set with done when divisor was 0; held with result.

Behaviour:
- Reset: synchronous, active-high; one clk edge with reset=1 forces:
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - result=0, counter=0
- Reset mid-operation aborts the division immediately; no done pulse is produced.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch operands, record sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB], and load abs values (the abs of the most-negative value is taken as an unsigned WIDTH-bit magnitude).
    - If divisor==0: go to DONE.
    - Otherwise: go to RUN with counter=0 and partial remainder=0.
  - RUN: busy=1. Each edge performs one restoring step:
    - shift {rem, quo} left by 1;
    - trial = rem - |divisor| (WIDTH+1 bits);
    - if trial is non-negative, rem=trial and quotient LSB=1, else 0.
    - counter increments. The edge performing step WIDTH (counter==WIDTH-1) loads result with sign-corrected values and goes to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle; next edge goes to IDLE (busy=0). start is ignored in DONE.
- Sign correction:
  - quotient negated if sign_q;
  - remainder negated if sign_r (remainder takes the sign of the dividend; quotient truncates toward zero).
- Overflow: most-negative / -1 yields quotient = most-negative (wrap), remainder = 0; no flag.
- Divide by zero: result = {dividend, all-ones}, div_by_zero=1; done is asserted in the cycle after the start edge.
- Latency (non-zero divisor): start sampled at edge E0 → done high in the cycle after edge E(WIDTH), i.e. 32 cycles for WIDTH=32. Next start is accepted on the edge after done, at the earliest.
- Outputs hold: result and div_by_zero hold their values until the next accepted start, which clears div_by_zero.
- Operand timing: operands are sampled only at the accepting edge, so later changes on Y/bus have no effect.
- start held high: a new division begins on the first IDLE edge after done.

Optional Feature:
- Macro: SEQ_DIV_UNSIGNED_EN.
- Defined:
  - Adds input port div_unsigned (1 bit), sampled with start.
  - When div_unsigned=1, operands are treated as unsigned magnitudes and no sign correction is applied.
  - Divide-by-zero behaviour is unchanged.
- Undefined: port absent; all divisions are signed.

Test Plan:
- dividend=100, divisor=7, start pulse → busy high 33 cycles; done 32 cycles after the start edge; result=64'h00000002_0000000E, div_by_zero=0.
- dividend=-100 (FFFFFF9C), divisor=7 → result=64'hFFFFFFFE_FFFFFFF2; dividend=100, divisor=-7 → result=64'h00000002_FFFFFFF2.
- dividend=5, divisor=0 → done one cycle after the start edge; result=64'h00000005_FFFFFFFF, div_by_zero=1. A following division 9/3 → result=64'h00000000_00000003, div_by_zero=0.
- dividend=32'h80000000, divisor=32'hFFFFFFFF → result=64'h00000000_80000000; also 0/-5 → result=0.
- Start 100/7, assert start again with 50/5 at RUN cycle 5 (ignored) → result=64'h00000002_0000000E. Start again, then assert reset at RUN cycle 10 → next cycle busy=0, done=0, result=0, and no done pulse follows.
- With SEQ_DIV_UNSIGNED_EN: FFFFFFFF/2 with div_unsigned=1 → result=64'h00000001_7FFFFFFF; with div_unsigned=0 → result=64'hFFFFFFFF_00000000.
